// File: rtl/min_max_leds.sv
// LED bar driver: decodes a value into a registered 2**VALSIZE-wide bar,
// optionally bounded by a min/max window whose upper part blinks with osc_i.
module min_max_leds #(
    parameter int VALSIZE = 4,
    parameter int ERRNO   = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [1:0]            com_i,
    input  logic [VALSIZE-1:0]    max_i,
    input  logic [VALSIZE-1:0]    min_i,
    input  logic                  osc_i,
    input  logic [VALSIZE-1:0]    val_i,
    output logic [2**VALSIZE-1:0] leds_o
);

    localparam int NLEDS = 2**VALSIZE;
    // One extra bit so LED indices and bounds never wrap when val_i is all ones.
    localparam int IDXW  = VALSIZE + 1;

    typedef enum logic [1:0] {
        CMD_WINDOW = 2'b00,
        CMD_LINEAR = 2'b01,
        CMD_OFF    = 2'b10,
        CMD_ON     = 2'b11
    } cmd_e;

    cmd_e            cmd;
    logic [IDXW-1:0] min_ext;
    logic [IDXW-1:0] max_ext;
    logic [IDXW-1:0] val_ext;
    logic [IDXW-1:0] idx;
    logic            in_window;
    logic [NLEDS-1:0] leds_d;
    logic [NLEDS-1:0] leds_q;

    assign cmd     = cmd_e'(com_i);
    assign min_ext = {1'b0, min_i};
    assign max_ext = {1'b0, max_i};
    assign val_ext = {1'b0, val_i};

    // An inverted window (min > max) can never contain val, so it blanks the bar.
    assign in_window = (min_ext <= val_ext) && (val_ext <= max_ext);

    always_comb begin
        leds_d = '0;
        idx    = '0;
        for (int i = 0; i < NLEDS; i++) begin
            idx = IDXW'(i);
            case (cmd)
                CMD_WINDOW: begin
                    if (in_window) begin
                        leds_d[i] = ((idx >= min_ext) && (idx <= val_ext)) ||
                                    (osc_i && (idx > val_ext) && (idx <= max_ext));
                    end
                end
                CMD_LINEAR: leds_d[i] = (idx <= val_ext);
                CMD_OFF:    leds_d[i] = 1'b0;
                CMD_ON:     leds_d[i] = 1'b1;
                default:    leds_d[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            leds_q <= '0;
        end else begin
            leds_q <= leds_d;
        end
    end

    assign leds_o = leds_q;

endmodule

// File: tb/tb_min_max_leds.sv
// Scoreboard bench for min_max_leds (VALSIZE=4): expectations are queued when
// inputs are driven and compared one edge later.
module tb_min_max_leds;

    logic        clk_i;
    logic        rst_i;
    logic [1:0]  com_i;
    logic [3:0]  max_i;
    logic [3:0]  min_i;
    logic        osc_i;
    logic [3:0]  val_i;
    logic [15:0] leds_o;

    int errors;
    int checks;

    typedef struct {
        string       name;
        logic        rst;
        logic [1:0]  com;
        logic [3:0]  mn;
        logic [3:0]  mx;
        logic [3:0]  v;
        logic        osc;
        logic [15:0] exp;
    } vec_t;

    logic [15:0] exp_q[$];
    string       name_q[$];

    min_max_leds #(.VALSIZE(4), .ERRNO(0)) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .com_i  (com_i),
        .max_i  (max_i),
        .min_i  (min_i),
        .osc_i  (osc_i),
        .val_i  (val_i),
        .leds_o (leds_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Independent mask-based reference for the randomized scenario.
    function automatic logic [15:0] model(input logic [1:0] c, input int mn, input int mx,
                                          input int v, input logic o);
        int upto_v;
        int upto_mx;
        int below_mn;
        int r;
        upto_v   = (2 << v) - 1;
        upto_mx  = (2 << mx) - 1;
        below_mn = (1 << mn) - 1;
        r = 0;
        case (c)
            2'b00: if (mn <= v && v <= mx) r = (upto_v & ~below_mn) | (o ? (upto_mx & ~upto_v) : 0);
            2'b01: r = upto_v;
            2'b10: r = 0;
            default: r = 32'h0000_FFFF;
        endcase
        return r[15:0];
    endfunction

    task automatic drive(input vec_t t);
        @(negedge clk_i);
        rst_i = t.rst;
        com_i = t.com;
        min_i = t.mn;
        max_i = t.mx;
        val_i = t.v;
        osc_i = t.osc;
        exp_q.push_back(t.exp);
        name_q.push_back(t.name);
    endtask

    task automatic test_reset();
        vec_t tbl[$];
        logic [15:0] e;
        string n;
        tbl.push_back('{"rst_edge1",   1'b1, 2'b11, 4'd0, 4'd0, 4'd0, 1'b0, 16'h0000});
        tbl.push_back('{"rst_edge2",   1'b1, 2'b11, 4'd0, 4'd0, 4'd0, 1'b0, 16'h0000});
        tbl.push_back('{"rst_release", 1'b0, 2'b11, 4'd0, 4'd0, 4'd0, 1'b0, 16'hFFFF});
        tbl.push_back('{"rst_mid_op",  1'b1, 2'b11, 4'd0, 4'd0, 4'd0, 1'b0, 16'h0000});
        tbl.push_back('{"rst_reload",  1'b0, 2'b01, 4'd0, 4'd0, 4'd5, 1'b0, 16'h003F});
        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k]);
            @(posedge clk_i); #1;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (leds_o !== e) begin
                errors++;
                $display("FAIL %s: leds_o=%h expected %h", n, leds_o, e);
            end
        end
    endtask

    task automatic test_window();
        vec_t tbl[$];
        logic [15:0] e;
        string n;
        tbl.push_back('{"win_osc1",     1'b0, 2'b00, 4'd3,  4'd12, 4'd8,  1'b1, 16'h1FF8});
        tbl.push_back('{"win_osc0",     1'b0, 2'b00, 4'd3,  4'd12, 4'd8,  1'b0, 16'h01F8});
        tbl.push_back('{"win_below",    1'b0, 2'b00, 4'd3,  4'd12, 4'd2,  1'b1, 16'h0000});
        tbl.push_back('{"win_above",    1'b0, 2'b00, 4'd3,  4'd12, 4'd13, 1'b1, 16'h0000});
        tbl.push_back('{"win_inverted", 1'b0, 2'b00, 4'd10, 4'd5,  4'd7,  1'b1, 16'h0000});
        tbl.push_back('{"win_single",   1'b0, 2'b00, 4'd7,  4'd7,  4'd7,  1'b1, 16'h0080});
        tbl.push_back('{"win_val_max",  1'b0, 2'b00, 4'd2,  4'd9,  4'd9,  1'b1, 16'h03FC});
        tbl.push_back('{"win_full_o1",  1'b0, 2'b00, 4'd0,  4'd15, 4'd15, 1'b1, 16'hFFFF});
        tbl.push_back('{"win_full_o0",  1'b0, 2'b00, 4'd0,  4'd15, 4'd15, 1'b0, 16'hFFFF});
        tbl.push_back('{"win_top_nowrap",1'b0,2'b00, 4'd12, 4'd15, 4'd15, 1'b1, 16'hF000});
        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k]);
            @(posedge clk_i); #1;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (leds_o !== e) begin
                errors++;
                $display("FAIL %s: leds_o=%h expected %h", n, leds_o, e);
            end
        end
    endtask

    task automatic test_linear_and_const();
        vec_t tbl[$];
        logic [15:0] e;
        string n;
        tbl.push_back('{"lin_5",    1'b0, 2'b01, 4'd9, 4'd2, 4'd5,  1'b0, 16'h003F});
        tbl.push_back('{"lin_0",    1'b0, 2'b01, 4'd9, 4'd2, 4'd0,  1'b1, 16'h0001});
        tbl.push_back('{"lin_15",   1'b0, 2'b01, 4'd0, 4'd0, 4'd15, 1'b0, 16'hFFFF});
        tbl.push_back('{"off_any",  1'b0, 2'b10, 4'd3, 4'd12,4'd8,  1'b1, 16'h0000});
        tbl.push_back('{"on_any",   1'b0, 2'b11, 4'd10,4'd5, 4'd7,  1'b0, 16'hFFFF});
        tbl.push_back('{"off_after",1'b0, 2'b10, 4'd0, 4'd15,4'd15, 1'b1, 16'h0000});
        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k]);
            @(posedge clk_i); #1;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (leds_o !== e) begin
                errors++;
                $display("FAIL %s: leds_o=%h expected %h", n, leds_o, e);
            end
        end
    endtask

    task automatic test_blink();
        vec_t t;
        logic [15:0] e;
        string n;
        for (int k = 0; k < 8; k++) begin
            t = '{"blink", 1'b0, 2'b00, 4'd3, 4'd12, 4'd8, k[0], (k[0] ? 16'h1FF8 : 16'h01F8)};
            drive(t);
            @(posedge clk_i); #1;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (leds_o !== e) begin
                errors++;
                $display("FAIL %s[%0d]: leds_o=%h expected %h", n, k, leds_o, e);
            end
        end
    endtask

    task automatic test_random();
        vec_t t;
        logic [15:0] e;
        string n;
        for (int k = 0; k < 60; k++) begin
            t.name = "random";
            t.rst  = 1'b0;
            t.com  = 2'($urandom_range(0, 3));
            t.mn   = 4'($urandom_range(0, 15));
            t.mx   = 4'($urandom_range(0, 15));
            t.v    = 4'($urandom_range(0, 15));
            t.osc  = 1'($urandom_range(0, 1));
            t.exp  = model(t.com, int'(t.mn), int'(t.mx), int'(t.v), t.osc);
            drive(t);
            @(posedge clk_i); #1;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (leds_o !== e) begin
                errors++;
                $display("FAIL %s[%0d] com=%0d min=%0d max=%0d val=%0d osc=%0d: leds_o=%h expected %h",
                         n, k, t.com, t.mn, t.mx, t.v, t.osc, leds_o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t tbl[$];
        logic [15:0] e;
        string n;
        tbl.push_back('{"b2b_on",   1'b0, 2'b11, 4'd0, 4'd0,  4'd0, 1'b0, 16'hFFFF});
        tbl.push_back('{"b2b_off",  1'b0, 2'b10, 4'd0, 4'd0,  4'd0, 1'b0, 16'h0000});
        tbl.push_back('{"b2b_lin",  1'b0, 2'b01, 4'd0, 4'd0,  4'd3, 1'b0, 16'h000F});
        tbl.push_back('{"b2b_win",  1'b0, 2'b00, 4'd1, 4'd6,  4'd3, 1'b1, 16'h007E});
        tbl.push_back('{"b2b_rst",  1'b1, 2'b00, 4'd1, 4'd6,  4'd3, 1'b1, 16'h0000});
        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k]);
            @(posedge clk_i); #1;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (leds_o !== e) begin
                errors++;
                $display("FAIL %s: leds_o=%h expected %h", n, leds_o, e);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_i  = 1'b1;
        com_i  = 2'b11;
        min_i  = '0;
        max_i  = '0;
        val_i  = '0;
        osc_i  = 1'b0;
        test_reset();
        test_window();
        test_linear_and_const();
        test_blink();
        test_random();
        test_back_to_back();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
